// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative right shifter: op encodings, FSM state
// encodings and the stage-index width helper.
package shifter_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_SHR  = 2'b00;
    localparam op_t OP_ROTR = 2'b01;
    localparam op_t OP_SRA  = 2'b10;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Bits needed to index the shift-amount vector; at least one so a
    // 1-bit amount still has a legal index register.
    function automatic int stage_index_width(input int shamt_w);
        return (shamt_w > 1) ? $clog2(shamt_w) : 1;
    endfunction

endpackage

// File: rtl/right_shift_stage.sv
// One conditional right-shift stage by 2^stage bits, shared across all stages.
// RSHIFT_ARITH_EN adds the sign-fill path for OP_SRA; otherwise OP_SRA is logical.
module right_shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH),
    localparam int K_W = stage_index_width(SHAMT_W)
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic [K_W-1:0]   stage,
    input  logic [1:0]       op,
    input  logic             sign,
    output logic [WIDTH-1:0] shifted
);

    localparam int AMT_W = SHAMT_W + 1;
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] logical;
    logic [WIDTH-1:0] rotated;
    logic [WIDTH-1:0] result;

    // Largest stage amount is WIDTH/2, so W_AMT - amount never underflows.
    assign amount = AMT_W'(1) << stage;

`ifndef RSHIFT_ARITH_EN
    logic sign_unused;
    assign sign_unused = sign;
`endif

    always_comb begin
        logical = data >> amount;
        rotated = logical | (data << (W_AMT - amount));
        result  = logical;
        if (op == OP_ROTR) begin
            result = rotated;
        end
`ifdef RSHIFT_ARITH_EN
        else if (op == OP_SRA && sign) begin
            result = logical | ~({WIDTH{1'b1}} >> amount);
        end
`endif
        shifted = enable ? result : data;
    end

endmodule

// File: rtl/iterative_right_shifter.sv
// Multi-cycle SHR/ROTR/SRA unit: one right-shift stage per clock, MSB stage first.
// RSHIFT_ARITH_EN enables sign fill for op 10; without it op 10 runs as SHR.
module iterative_right_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy,
    output logic [1:0]         fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and in_ready never looks at in_valid.

    localparam int K_W = stage_index_width(SHAMT_W);
    localparam logic [K_W-1:0] K_INIT = K_W'(SHAMT_W - 1);

    state_t             state;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [1:0]         op_q;
    logic [K_W-1:0]     k_q;
    logic [WIDTH-1:0]   result_q;
    logic               sign_bit;
    logic [WIDTH-1:0]   stage_out;
    logic               accept;

    assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign out_data  = result_q;
    assign busy      = (state == ST_SHIFT);
    assign fsm_state = state;

`ifdef RSHIFT_ARITH_EN
    logic sign_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sign_q <= 1'b0;
        end else if (accept) begin
            sign_q <= in_data[WIDTH-1];
        end
    end

    assign sign_bit = sign_q;
`else
    assign sign_bit = 1'b0;
`endif

    right_shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .data    (data_q),
        .enable  (shamt_q[k_q]),
        .stage   (k_q),
        .op      (op_q),
        .sign    (sign_bit),
        .shifted (stage_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            data_q   <= '0;
            shamt_q  <= '0;
            op_q     <= '0;
            k_q      <= '0;
            result_q <= '0;
        end else if (accept) begin
            // Covers both IDLE and a back-to-back accept out of DONE.
            state   <= ST_SHIFT;
            data_q  <= in_data;
            shamt_q <= in_shamt;
            op_q    <= in_op;
            k_q     <= K_INIT;
        end else if (state == ST_DONE && out_ready) begin
            state <= ST_IDLE;
        end else if (state == ST_SHIFT) begin
            data_q <= stage_out;
            if (k_q == '0) begin
                state    <= ST_DONE;
                result_q <= stage_out;
            end else begin
                k_q <= k_q - 1'b1;
            end
        end
    end

endmodule

// File: doc/iterative_right_shifter.md
Name: iterative_right_shifter

Overview:
- Multi-cycle right shift/rotate unit for the SHA-256 datapath of the miner; covers the ROTR and SHR operations used by the sigma functions.
- Mirror direction of the existing fixed left barrel stages: applies one conditional right-shift stage per clock.
- Stage order is 2^(S-1) down to 2^0.
- Sits between the message-schedule/compression control and the adder tree, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, data width; must be a power of two, minimum 2.
- SHAMT_W, derived localparam = log2(WIDTH) (5 at default); not overridable.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- in_op  input  2  00 SHR logical, 01 ROTR, 10 SRA, 11 reserved (executes as SHR)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH  result
- busy  output  1  high in SHIFT state

Behaviour:
- Reset (async, immediate): state IDLE, out_valid=0, out_data=0, busy=0, internal data/shamt/op/stage registers=0, in_ready=1 once reset deasserts.
- FSM states: IDLE, SHIFT, DONE.
- Accept: in_valid && in_ready at a rising edge.
  - Latches in_data, in_shamt, in_op.
  - Stage index k = SHAMT_W-1.
  - State -> SHIFT.
- SHIFT: each edge, if shamt[k]=1, data is shifted right by 2^k:
  - SHR: fill with zeros.
  - ROTR: low bits wrap to the MSBs.
  - SRA: fill with the operand MSB, latched at accept.
  - If shamt[k]=0: data unchanged.
  - If k==0: state -> DONE; otherwise k decrements.
- Latency: fixed SHAMT_W cycles. out_valid is first high SHAMT_W edges after the accept edge, independent of shamt value (shamt=0 also takes SHAMT_W cycles).
- DONE: out_valid=1, out_data holds the result stable until out_ready.
  - out_ready=1 and in_valid=0: state -> IDLE.
  - out_ready=1 and in_valid=1: new request accepted on the same edge, state -> SHIFT (back-to-back).
  - out_ready=0: out_valid, out_data, state all held; in_ready=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from state and out_ready only; no path from in_valid.
- in_valid in SHIFT is ignored; no queueing.
- out_data is only meaningful while out_valid=1. It keeps the last result after the handoff.
- reset asserted mid-SHIFT or in DONE: in-flight operation dropped, no out_valid pulse, all state returns to reset values.
- Widths: no truncation beyond WIDTH; in_shamt interpreted unsigned.

Optional Feature:
- Macro: RSHIFT_ARITH_EN.
- Defined: in_op=10 performs arithmetic right shift (sign fill).
- Undefined: in_op=10 executes as logical SHR. The sign-latch register and fill mux are not synthesized.

Decomposition:
- Shared package shifter_pkg:
  - op encodings: OP_SHR=2'b00, OP_ROTR=2'b01, OP_SRA=2'b10.
  - FSM state enum: IDLE, SHIFT, DONE.
- Sub-module right_shift_stage:
  - Combinational; inputs: data, enable, amount 2^k selected by stage index, op, sign bit.
  - Output: shifted data.
  - Right-direction counterpart of the existing left barrel stages.
  - Instantiated once and time-multiplexed across stages by k.

Test Plan:
- ROTR, in_data=0x80000001, shamt=4 -> out_data=0x18000000, out_valid exactly 5 cycles after accept.
- SHR, in_data=0xFFFFFFFF, shamt=16 -> 0x0000FFFF. SHR, 0x12345678, shamt=0 -> 0x12345678 after 5 cycles.
- SRA, 0x80000000, shamt=31:
  - With RSHIFT_ARITH_EN -> 0xFFFFFFFF.
  - Without -> 0x00000001.
- Backpressure: result 0x0000FFFF pending, out_ready=0 for 10 cycles -> out_valid/out_data stable, in_ready=0; on out_ready=1 with in_valid=1 (ROTR 0x00000001, shamt=1), the new request is accepted on the same edge and the next result 0x80000000 arrives 5 cycles later.
- Reset mid-op: assert reset during the 3rd SHIFT cycle -> out_valid=0, busy=0, in_ready=1 after release, no stale result ever presented.
- Reserved op 11, 0xF0000000, shamt=4 -> 0x0F000000 (SHR behaviour).
